// File: rtl/axil_frontend_ldmx.sv
// AXI4-Lite slave front-end for the LDMX register space: one outstanding read and one
// outstanding write, bridged onto the strobe/valid interface of the merge/decode stage.
//
// state   | meaning
// R_IDLE  | ready for AR; latch address and issue m_rstart (or flag out-of-range)
// R_WAIT  | m_rstart issued; m_rready high until merge returns m_rvalid
// R_RESP  | s_rvalid high with latched data/response
// R_DRAIN | R beat accepted; wait for merge to drop a lingering m_rvalid
// W_IDLE  | collect AW and W beats independently, in any order
// W_ISSUE | one-cycle m_wstart with address/data/strobes presented
// W_WAIT  | m_bready high until merge returns m_bvalid
// W_RESP  | s_bvalid high with latched response
// W_DRAIN | B beat accepted; wait for merge to drop a lingering m_bvalid
module axil_frontend_ldmx #(
  parameter int ADDR_WIDTH = 32,
  parameter int ADDR_LSB   = 2
) (
  input  logic                  axilClk,
  input  logic                  axilRstN,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [17:0]           m_raddr,
  output logic                  m_rstart,
  output logic                  m_rready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic [17:0]           m_waddr,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  output logic                  m_wstart,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP, R_DRAIN} r_state_t;
  typedef enum logic [2:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP, W_DRAIN} w_state_t;

  r_state_t r_state, r_state_nxt;
  w_state_t w_state, w_state_nxt;

  logic ar_fire, ar_oor;
  logic aw_fire, w_fire, aw_oor;
  logic aw_held, w_held, aw_oor_q;
  logic have_aw, have_w, addr_bad;
  logic unused_m_wready;

  // m_wready is informational only; the write completes on m_bvalid.
  assign unused_m_wready = m_wready;

  assign ar_oor  = (s_araddr >> (ADDR_LSB + 18)) != '0;
  assign ar_fire = s_arvalid && (r_state == R_IDLE);

  assign s_arready = (r_state == R_IDLE);
  assign m_rready  = (r_state == R_WAIT);
  assign s_rvalid  = (r_state == R_RESP);

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) r_state <= R_IDLE;
    else           r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (s_arvalid) r_state_nxt = ar_oor ? R_RESP : R_WAIT;
      R_WAIT:  if (m_rvalid) r_state_nxt = R_RESP;
      R_RESP:  if (s_rready) r_state_nxt = m_rvalid ? R_DRAIN : R_IDLE;
      R_DRAIN: if (!m_rvalid) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) begin
      m_raddr  <= '0;
      m_rstart <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= '0;
    end else begin
      m_rstart <= 1'b0;
      if (ar_fire) begin
        if (ar_oor) begin
          s_rdata <= '0;
          s_rresp <= 2'b11;
        end else begin
          m_raddr  <= s_araddr[ADDR_LSB+17:ADDR_LSB];
          m_rstart <= 1'b1;
        end
      end
      if ((r_state == R_WAIT) && m_rvalid) begin
        s_rdata <= m_rdata;
        s_rresp <= m_rresp;
      end
    end
  end

  // A beat captured this cycle counts as held, so issue follows the last beat directly.
  assign aw_oor   = (s_awaddr >> (ADDR_LSB + 18)) != '0;
  assign aw_fire  = s_awvalid && s_awready;
  assign w_fire   = s_wvalid && s_wready;
  assign have_aw  = aw_held || aw_fire;
  assign have_w   = w_held || w_fire;
  assign addr_bad = aw_held ? aw_oor_q : aw_oor;

  assign s_awready = (w_state == W_IDLE) && !aw_held;
  assign s_wready  = (w_state == W_IDLE) && !w_held;
  assign m_wstart  = (w_state == W_ISSUE);
  assign m_bready  = (w_state == W_WAIT);
  assign s_bvalid  = (w_state == W_RESP);

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) w_state <= W_IDLE;
    else           w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (have_aw && have_w) w_state_nxt = addr_bad ? W_RESP : W_ISSUE;
      W_ISSUE: w_state_nxt = W_WAIT;
      W_WAIT:  if (m_bvalid) w_state_nxt = W_RESP;
      W_RESP:  if (s_bready) w_state_nxt = m_bvalid ? W_DRAIN : W_IDLE;
      W_DRAIN: if (!m_bvalid) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge axilClk or negedge axilRstN) begin
    if (!axilRstN) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_oor_q <= 1'b0;
      m_waddr  <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      s_bresp  <= '0;
    end else begin
      if (aw_fire) begin
        m_waddr  <= s_awaddr[ADDR_LSB+17:ADDR_LSB];
        aw_oor_q <= aw_oor;
      end
      if (w_fire) begin
        m_wdata <= s_wdata;
        m_wstrb <= s_wstrb;
      end
      if ((w_state == W_IDLE) && (w_state_nxt != W_IDLE)) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire)  w_held  <= 1'b1;
      end
      if ((w_state == W_IDLE) && have_aw && have_w && addr_bad) s_bresp <= 2'b11;
      if ((w_state == W_WAIT) && m_bvalid) s_bresp <= m_bresp;
    end
  end

endmodule

// File: tb/tb_axil_frontend_ldmx.sv
// Scenario bench for axil_frontend_ldmx: inputs driven and outputs sampled on the
// falling edge, expected responses queued at stimulus time and popped on s_rvalid/s_bvalid.
module tb_axil_frontend_ldmx;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic        axilClk = 1'b0;
  logic        axilRstN = 1'b0;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [17:0] m_raddr;
  logic        m_rstart;
  logic        m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic [17:0] m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wstart;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = '0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;

  rexp_t       exp_r_q[$];
  logic [1:0]  exp_b_q[$];
  logic [17:0] exp_ra_q[$];

  int tests_run = 0;
  int tests_failed = 0;
  int n_rstart = 0, n_wstart = 0, n_rbeat = 0, n_bbeat = 0;
  logic rv_q = 1'b0, bv_q = 1'b0;

  axil_frontend_ldmx #(.ADDR_WIDTH(32), .ADDR_LSB(2)) dut (
    .axilClk(axilClk), .axilRstN(axilRstN),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_raddr(m_raddr), .m_rstart(m_rstart), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wstart(m_wstart),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 axilClk = ~axilClk;

  // Pulse and beat counters; a beat is a rising edge of s_rvalid/s_bvalid.
  always @(negedge axilClk) begin
    if (m_rstart) n_rstart++;
    if (m_wstart) n_wstart++;
    if (s_rvalid && !rv_q) n_rbeat++;
    if (s_bvalid && !bv_q) n_bbeat++;
    rv_q = s_rvalid;
    bv_q = s_bvalid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] word_of(input logic [31:0] a);
    return a[19:2];
  endfunction

  task automatic test_reset();
    axilRstN = 1'b0;
    repeat (2) @(negedge axilClk);
    tests_run++;
    if ({s_arready, s_awready, s_wready} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b required 111", {s_arready, s_awready, s_wready});
    end
    tests_run++;
    if ({s_rvalid, s_bvalid, m_rstart, m_wstart, m_rready, m_bready} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {s_rvalid, s_bvalid, m_rstart, m_wstart, m_rready, m_bready});
    end
    tests_run++;
    if ({s_rdata, s_rresp, s_bresp, m_raddr, m_waddr, m_wdata, m_wstrb} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: rdata=%h raddr=%h waddr=%h wdata=%h required all 0",
               s_rdata, m_raddr, m_waddr, m_wdata);
    end
    axilRstN = 1'b1;
    @(negedge axilClk);
  endtask

  task automatic test_read_basic();
    int r0, b0;
    rexp_t e;
    logic [17:0] ea;
    r0 = n_rstart; b0 = n_rbeat;
    exp_ra_q.push_back(word_of(32'h0000_0400));
    exp_r_q.push_back('{data: 32'hDEADBEEF, resp: 2'b00});
    s_araddr = 32'h0000_0400; s_arvalid = 1'b1;
    @(negedge axilClk);
    s_arvalid = 1'b0;
    ea = exp_ra_q.pop_front();
    tests_run++;
    if (m_rstart !== 1'b1 || m_raddr !== ea) begin
      tests_failed++;
      $display("FAIL rd_start: rstart=%b raddr=%h required rstart=1 raddr=%h", m_rstart, m_raddr, ea);
    end
    @(negedge axilClk);
    tests_run++;
    if (m_rstart !== 1'b0 || m_rready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_pulse: rstart=%b rready=%b required rstart=0 rready=1", m_rstart, m_rready);
    end
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
    @(negedge axilClk);
    m_rvalid = 1'b0; m_rdata = '0;
    tests_run++;
    if (s_rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_latency: s_rvalid=%b required 1 one cycle after m_rvalid", s_rvalid);
    end
    e = exp_r_q.pop_front();
    tests_run++;
    if ({s_rdata, s_rresp} !== e) begin
      tests_failed++;
      $display("FAIL rd_data: got %h/%0d required %h/%0d", s_rdata, s_rresp, e.data, e.resp);
    end
    s_rready = 1'b1;
    @(negedge axilClk);
    s_rready = 1'b0;
    @(negedge axilClk);
    tests_run++;
    if ((n_rbeat - b0) != 1 || (n_rstart - r0) != 1 || s_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_count: beats=%0d starts=%0d arready=%b required 1 1 1",
               n_rbeat - b0, n_rstart - r0, s_arready);
    end
  endtask

  task automatic test_read_linger();
    int b0, bad_at;
    rexp_t e;
    logic [17:0] ea;
    b0 = n_rbeat; bad_at = -1;
    exp_ra_q.push_back(word_of(32'h0000_0800));
    exp_r_q.push_back('{data: 32'h0BADF00D, resp: 2'b10});
    s_araddr = 32'h0000_0800; s_arvalid = 1'b1;
    @(negedge axilClk);
    s_arvalid = 1'b0;
    ea = exp_ra_q.pop_front();
    tests_run++;
    if (m_raddr !== ea) begin
      tests_failed++;
      $display("FAIL lg_addr: raddr=%h required %h", m_raddr, ea);
    end
    m_rvalid = 1'b1; m_rdata = 32'h0BADF00D; m_rresp = 2'b10;
    @(negedge axilClk);
    m_rdata = 32'h1111_2222;
    e = exp_r_q.pop_front();
    tests_run++;
    if (s_rvalid !== 1'b1 || {s_rdata, s_rresp} !== e) begin
      tests_failed++;
      $display("FAIL lg_data: rvalid=%b got %h/%0d required 1 %h/%0d", s_rvalid, s_rdata, s_rresp, e.data, e.resp);
    end
    for (int i = 0; i < 10; i++) begin
      if (bad_at < 0 && (s_arready !== 1'b0 || s_rvalid !== 1'b1 || s_rdata !== e.data)) bad_at = i;
      if (i == 3) m_rvalid = 1'b0;
      @(negedge axilClk);
    end
    tests_run++;
    if (bad_at >= 0) begin
      tests_failed++;
      $display("FAIL lg_hold: first bad cycle %0d, arready/rvalid not 0/1 or data moved, required held", bad_at);
    end
    s_rready = 1'b1;
    @(negedge axilClk);
    s_rready = 1'b0;
    @(negedge axilClk);
    tests_run++;
    if (s_arready !== 1'b1 || (n_rbeat - b0) != 1) begin
      tests_failed++;
      $display("FAIL lg_done: arready=%b beats=%0d required 1 1", s_arready, n_rbeat - b0);
    end
  endtask

  task automatic test_read_drain();
    int b0;
    rexp_t e;
    b0 = n_rbeat;
    exp_r_q.push_back('{data: 32'h5555AAAA, resp: 2'b00});
    s_araddr = 32'h0000_0C00; s_arvalid = 1'b1;
    @(negedge axilClk);
    s_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h5555AAAA; m_rresp = 2'b00;
    @(negedge axilClk);
    m_rdata = 32'hFFFF0000;
    e = exp_r_q.pop_front();
    tests_run++;
    if (s_rvalid !== 1'b1 || {s_rdata, s_rresp} !== e) begin
      tests_failed++;
      $display("FAIL dr_data: rvalid=%b got %h required 1 %h", s_rvalid, s_rdata, e.data);
    end
    s_rready = 1'b1;
    @(negedge axilClk);
    s_rready = 1'b0;
    tests_run++;
    if (s_rvalid !== 1'b0 || s_arready !== 1'b0) begin
      tests_failed++;
      $display("FAIL dr_wait: rvalid=%b arready=%b required 0 0 while m_rvalid lingers", s_rvalid, s_arready);
    end
    @(negedge axilClk);
    m_rvalid = 1'b0;
    @(negedge axilClk);
    tests_run++;
    if (s_arready !== 1'b1 || s_rdata !== e.data || (n_rbeat - b0) != 1) begin
      tests_failed++;
      $display("FAIL dr_done: arready=%b rdata=%h beats=%0d required 1 %h 1",
               s_arready, s_rdata, n_rbeat - b0, e.data);
    end
  endtask

  task automatic test_out_of_range();
    int r0, w0;
    rexp_t e;
    logic [1:0] eb;
    r0 = n_rstart; w0 = n_wstart;
    exp_r_q.push_back('{data: 32'h0, resp: 2'b11});
    exp_b_q.push_back(2'b11);
    s_araddr = 32'h0010_0000; s_arvalid = 1'b1;
    s_awaddr = 32'h0010_0000; s_awvalid = 1'b1;
    s_wdata = 32'h0000_0077; s_wstrb = 4'h1; s_wvalid = 1'b1;
    @(negedge axilClk);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int k = 0; k < 8 && !(s_rvalid && s_bvalid); k++) @(negedge axilClk);
    tests_run++;
    if (s_rvalid !== 1'b1 || s_bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_resp: rvalid=%b bvalid=%b required 1 1 within 8 cycles", s_rvalid, s_bvalid);
    end
    e = exp_r_q.pop_front();
    eb = exp_b_q.pop_front();
    tests_run++;
    if ({s_rdata, s_rresp} !== e || s_bresp !== eb) begin
      tests_failed++;
      $display("FAIL oor_code: rdata=%h rresp=%0d bresp=%0d required 0 3 3", s_rdata, s_rresp, s_bresp);
    end
    s_rready = 1'b1; s_bready = 1'b1;
    @(negedge axilClk);
    s_rready = 1'b0; s_bready = 1'b0;
    @(negedge axilClk);
    tests_run++;
    if ({s_arready, s_awready, s_wready} !== 3'b111 || (n_rstart - r0) != 0 || (n_wstart - w0) != 0) begin
      tests_failed++;
      $display("FAIL oor_idle: ready=%b rstarts=%0d wstarts=%0d required 111 0 0",
               {s_arready, s_awready, s_wready}, n_rstart - r0, n_wstart - w0);
    end
  endtask

  task automatic test_write_w_first();
    int w0, bb0;
    bit bad;
    logic [17:0] ewa;
    logic [1:0] eb;
    w0 = n_wstart; bb0 = n_bbeat; bad = 1'b0;
    ewa = word_of(32'h0004_4000);
    exp_b_q.push_back(2'b00);
    s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge axilClk);
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    tests_run++;
    if (s_wready !== 1'b0 || s_awready !== 1'b1 || m_wstart !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_wbeat: wready=%b awready=%b wstart=%b required 0 1 0", s_wready, s_awready, m_wstart);
    end
    repeat (2) @(negedge axilClk);
    s_awaddr = 32'h0004_4000; s_awvalid = 1'b1;
    @(negedge axilClk);
    s_awvalid = 1'b0; s_awaddr = '0;
    for (int k = 0; k < 6 && !m_wstart; k++) @(negedge axilClk);
    tests_run++;
    if (m_wstart !== 1'b1 || m_waddr !== ewa || m_wdata !== 32'h12345678 || m_wstrb !== 4'hF) begin
      tests_failed++;
      $display("FAIL wr_issue: wstart=%b waddr=%h wdata=%h wstrb=%h required 1 %h 12345678 f",
               m_wstart, m_waddr, m_wdata, m_wstrb, ewa);
    end
    @(negedge axilClk);
    for (int i = 0; i < 4; i++) begin
      if (m_wstart !== 1'b0 || m_bready !== 1'b1 || s_bvalid !== 1'b0 ||
          m_waddr !== ewa || m_wdata !== 32'h12345678) bad = 1'b1;
      @(negedge axilClk);
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL wr_wait: wstart=%b bready=%b waddr=%h wdata=%h required 0 1 %h 12345678 held",
               m_wstart, m_bready, m_waddr, m_wdata, ewa);
    end
    m_bvalid = 1'b1; m_bresp = 2'b00;
    @(negedge axilClk);
    m_bvalid = 1'b0;
    eb = exp_b_q.pop_front();
    tests_run++;
    if (s_bvalid !== 1'b1 || s_bresp !== eb) begin
      tests_failed++;
      $display("FAIL wr_bresp: bvalid=%b bresp=%0d required 1 %0d", s_bvalid, s_bresp, eb);
    end
    s_bready = 1'b1;
    @(negedge axilClk);
    s_bready = 1'b0;
    @(negedge axilClk);
    tests_run++;
    if (s_awready !== 1'b1 || s_wready !== 1'b1 || (n_wstart - w0) != 1 || (n_bbeat - bb0) != 1) begin
      tests_failed++;
      $display("FAIL wr_done: awready=%b wready=%b wstarts=%0d bbeats=%0d required 1 1 1 1",
               s_awready, s_wready, n_wstart - w0, n_bbeat - bb0);
    end
  endtask

  task automatic test_concurrent();
    int r0, w0, rb0, bb0, rv_at, bv_at;
    bit drain_bad;
    rexp_t e;
    logic [1:0] eb;
    r0 = n_rstart; w0 = n_wstart; rb0 = n_rbeat; bb0 = n_bbeat;
    rv_at = -1; bv_at = -1; drain_bad = 1'b0;
    exp_r_q.push_back('{data: 32'h600DF00D, resp: 2'b01});
    exp_b_q.push_back(2'b01);
    s_araddr = 32'h0000_0400; s_arvalid = 1'b1;
    s_awaddr = 32'h0000_4000; s_awvalid = 1'b1;
    s_wdata = 32'hA5A5A5A5; s_wstrb = 4'h3; s_wvalid = 1'b1;
    @(negedge axilClk);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    tests_run++;
    if (m_rstart !== 1'b1 || m_raddr !== word_of(32'h0000_0400)) begin
      tests_failed++;
      $display("FAIL cc_rstart: rstart=%b raddr=%h required 1 00100", m_rstart, m_raddr);
    end
    for (int k = 0; k < 6 && !(m_rready && m_bready); k++) @(negedge axilClk);
    tests_run++;
    if (m_rready !== 1'b1 || m_bready !== 1'b1 || m_waddr !== word_of(32'h0000_4000) ||
        m_wdata !== 32'hA5A5A5A5 || m_wstrb !== 4'h3) begin
      tests_failed++;
      $display("FAIL cc_issue: rready=%b bready=%b waddr=%h wdata=%h wstrb=%h required 1 1 01000 a5a5a5a5 3",
               m_rready, m_bready, m_waddr, m_wdata, m_wstrb);
    end
    s_rready = 1'b1; s_bready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (s_rvalid) begin
        rv_at = i;
        e = exp_r_q.pop_front();
        tests_run++;
        if ({s_rdata, s_rresp} !== e) begin
          tests_failed++;
          $display("FAIL cc_rdata: got %h/%0d required %h/%0d", s_rdata, s_rresp, e.data, e.resp);
        end
      end
      if (s_bvalid) begin
        bv_at = i;
        eb = exp_b_q.pop_front();
        tests_run++;
        if (s_bresp !== eb) begin
          tests_failed++;
          $display("FAIL cc_bresp: got %0d required %0d", s_bresp, eb);
        end
      end
      if (i == 8 && s_awready !== 1'b0) drain_bad = 1'b1;
      m_rvalid = (i == 0);
      m_rdata  = (i == 0) ? 32'h600DF00D : 32'h0;
      m_rresp  = 2'b01;
      m_bvalid = (i >= 5 && i <= 8);
      m_bresp  = 2'b01;
      @(negedge axilClk);
    end
    s_rready = 1'b0; s_bready = 1'b0;
    tests_run++;
    if (rv_at != 1 || bv_at != 6) begin
      tests_failed++;
      $display("FAIL cc_timing: s_rvalid at %0d s_bvalid at %0d required 1 and 6", rv_at, bv_at);
    end
    tests_run++;
    if (drain_bad || s_awready !== 1'b1 || s_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cc_drain: awready in drain bad=%b, final awready=%b arready=%b required 0 1 1",
               drain_bad, s_awready, s_arready);
    end
    tests_run++;
    if ((n_rstart - r0) != 1 || (n_wstart - w0) != 1 || (n_rbeat - rb0) != 1 || (n_bbeat - bb0) != 1) begin
      tests_failed++;
      $display("FAIL cc_count: rstart=%0d wstart=%0d rbeat=%0d bbeat=%0d required 1 1 1 1",
               n_rstart - r0, n_wstart - w0, n_rbeat - rb0, n_bbeat - bb0);
    end
  endtask

  task automatic test_reset_midflight();
    int rb0, bb0, bad_at;
    bad_at = -1;
    s_araddr = 32'h0000_0400; s_arvalid = 1'b1;
    s_awaddr = 32'h0000_4000; s_awvalid = 1'b1;
    s_wdata = 32'h0F0F0F0F; s_wstrb = 4'hC; s_wvalid = 1'b1;
    @(negedge axilClk);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int k = 0; k < 6 && !(m_rready && m_bready); k++) @(negedge axilClk);
    tests_run++;
    if (m_rready !== 1'b1 || m_bready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_wait: rready=%b bready=%b required 1 1 before reset", m_rready, m_bready);
    end
    axilRstN = 1'b0;
    #1;
    tests_run++;
    if ({s_arready, s_awready, s_wready} !== 3'b111 ||
        {s_rvalid, s_bvalid, m_rstart, m_wstart, m_rready, m_bready} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rm_ctrl: ready=%b ctrl=%b required 111 000000", {s_arready, s_awready, s_wready},
               {s_rvalid, s_bvalid, m_rstart, m_wstart, m_rready, m_bready});
    end
    tests_run++;
    if ({s_rdata, s_rresp, s_bresp, m_raddr, m_waddr, m_wdata, m_wstrb} !== '0) begin
      tests_failed++;
      $display("FAIL rm_data: rdata=%h raddr=%h waddr=%h wdata=%h required all 0", s_rdata, m_raddr, m_waddr, m_wdata);
    end
    m_rvalid = 1'b1; m_rdata = 32'h99999999; m_bvalid = 1'b1; m_bresp = 2'b10;
    @(negedge axilClk);
    axilRstN = 1'b1;
    rb0 = n_rbeat; bb0 = n_bbeat;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin m_rvalid = 1'b0; m_bvalid = 1'b0; end
      @(negedge axilClk);
      if (bad_at < 0 && (s_rvalid !== 1'b0 || s_bvalid !== 1'b0 || s_arready !== 1'b1 || s_awready !== 1'b1))
        bad_at = i;
    end
    tests_run++;
    if (bad_at >= 0 || (n_rbeat - rb0) != 0 || (n_bbeat - bb0) != 0) begin
      tests_failed++;
      $display("FAIL rm_stale: first bad cycle %0d rbeats=%0d bbeats=%0d required none",
               bad_at, n_rbeat - rb0, n_bbeat - bb0);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_read_linger();
    test_read_drain();
    test_out_of_range();
    test_write_w_first();
    test_concurrent();
    test_reset_midflight();
    tests_run++;
    if (exp_r_q.size() != 0 || exp_b_q.size() != 0 || exp_ra_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_left: r=%0d b=%0d ra=%0d entries left, required 0",
               exp_r_q.size(), exp_b_q.size(), exp_ra_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
